// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 access encodings,
// FSM state type and the funct3 legality helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // Stores only exist in signed B/H/W form; loads also allow BU/HU.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the LSU: byte enables and store-data replication for the
// request being issued, access legality/alignment, and formatting of the
// returned cache word for the access currently in flight.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        bad,
   output logic [31:0] ld_fmt
);

   logic       legal;
   logic       misal;
   logic [7:0] lane_b;
   logic [15:0] lane_h;

   // Byte enables and replicated store data; funct3[1:0] gives the size,
   // so BU/HU loads get the same enables as B/H.
   always_comb begin
      be    = 4'b1111;
      wdata = st_data;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {addr_lo[1], 1'b0};
            wdata = {2{st_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = st_data;
         end
      endcase
   end

   // An access is rejected for an unsupported encoding or a size/address mismatch.
   always_comb begin
      legal = f3_legal(is_store, funct3);
      misal = 1'b0;
      if (funct3[1:0] == 2'b01 && addr_lo[0])
         misal = 1'b1;
      if (funct3[1:0] == 2'b10 && addr_lo != 2'b00)
         misal = 1'b1;
      bad = ~legal | misal;
   end

   // Pick the addressed lane of the returned word, then extend by access type.
   always_comb begin
      case (ld_addr_lo)
         2'b00:   lane_b = rdata[7:0];
         2'b01:   lane_b = rdata[15:8];
         2'b10:   lane_b = rdata[23:16];
         default: lane_b = rdata[31:24];
      endcase
      lane_h = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (ld_funct3)
         F3_B:    ld_fmt = {{24{lane_b[7]}}, lane_b};
         F3_H:    ld_fmt = {{16{lane_h[15]}}, lane_h};
         F3_BU:   ld_fmt = {24'd0, lane_b};
         F3_HU:   ld_fmt = {16'd0, lane_h};
         default: ld_fmt = rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Accepts one access per IDLE cycle, holds the
// request to the data cache until dc_ready, and stalls the pipeline for the
// IDLE and BUSY cycles. DONE is a one-cycle release so the pipeline can
// advance past the access before a new one is considered.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; a valid access stalls combinationally and is latched
// BUSY  | dc_req held with latched fields until dc_ready
// DONE  | stall released, inputs ignored, ld_data held
module mem_lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   output logic        dc_req,
   output logic        dc_we,
   output logic [31:0] dc_addr,
   output logic [31:0] dc_wdata,
   output logic [3:0]  dc_be,
   input  logic [31:0] dc_rdata,
   input  logic        dc_ready,
   output logic [31:0] ld_data,
   output logic        stall_cache,
   output logic        misalign
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] ld_data_q, ld_data_d;

   logic        acc_req;
   logic        is_store;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic        bad_c;
   logic [31:0] ld_fmt_c;

   assign acc_req  = mem_read | mem_write;
   assign is_store = mem_write;

   lsu_align u_align (
      .is_store   (is_store),
      .funct3     (funct3),
      .addr_lo    (addr[1:0]),
      .st_data    (st_data),
      .ld_funct3  (funct3_q),
      .ld_addr_lo (addr_q[1:0]),
      .rdata      (dc_rdata),
      .be         (be_c),
      .wdata      (wdata_c),
      .bad        (bad_c),
      .ld_fmt     (ld_fmt_c)
   );

   // Next-state and latch logic for the access sequencer.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      funct3_d  = funct3_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      ld_data_d = ld_data_q;
      case (state_q)
         IDLE: begin
            if (acc_req) begin
               if (bad_c) begin
                  ld_data_d = 32'd0;
               end else begin
                  we_d     = is_store;
                  addr_d   = addr;
                  funct3_d = funct3;
                  wdata_d  = wdata_c;
                  be_d     = be_c;
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            if (dc_ready) begin
               if (!we_q)
                  ld_data_d = ld_fmt_c;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched request fields; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= 32'd0;
         funct3_q  <= 3'd0;
         wdata_q   <= 32'd0;
         be_q      <= 4'd0;
         ld_data_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         funct3_q  <= funct3_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         ld_data_q <= ld_data_d;
      end
   end

   // Outputs: IDLE-cycle terms are combinational and gated by reset so a
   // request present during reset cannot stall or flag.
   always_comb begin
      dc_req      = (state_q == BUSY);
      dc_we       = we_q;
      dc_addr     = {addr_q[31:2], 2'b00};
      dc_wdata    = wdata_q;
      dc_be       = be_q;
      ld_data     = ld_data_q;
      stall_cache = ~rst & ((state_q == BUSY) |
                            ((state_q == IDLE) & acc_req & ~bad_c));
      misalign    = ~rst & (state_q == IDLE) & acc_req & bad_c;
   end

endmodule
